// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM FIFO arbiter:
//   - arbiter state encoding
//   - SDRAM address width and write/read burst length widths
//   - next_ptr(): circular frame-buffer pointer advance with wrap
// No ports (package).
// -----------------------------------------------------------------------------
package sdram_pkg;

    localparam int ADDR_W     = 21;
    localparam int WR_BURST_W = 9;
    localparam int RD_BURST_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_REQ   = 3'd1,
        ST_WR_BURST = 3'd2,
        ST_RD_REQ   = 3'd3,
        ST_RD_BURST = 3'd4
    } state_e;

    // Advance a burst pointer by one burst. The sum is formed one bit wider
    // than the address so a pointer near the top of the address space cannot
    // alias to a small value. The pointer wraps early when the *following*
    // burst would no longer fit below max_addr, so a burst never straddles
    // the end of the region.
    function automatic logic [ADDR_W-1:0] next_ptr(
        input logic [ADDR_W-1:0]     ptr,
        input logic [RD_BURST_W-1:0] len,
        input logic [ADDR_W-1:0]     min_addr,
        input logic [ADDR_W-1:0]     max_addr
    );
        logic [ADDR_W:0]     len_ext;
        logic [ADDR_W:0]     nxt;
        logic [ADDR_W-1:0]   result;
        len_ext = {{(ADDR_W + 1 - RD_BURST_W){1'b0}}, len};
        nxt     = {1'b0, ptr} + len_ext;
        if ((nxt + len_ext) > {1'b0, max_addr}) begin
            result = min_addr;
        end else begin
            result = nxt[ADDR_W-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/sdram_fifo_arbiter_if.sv
// -----------------------------------------------------------------------------
// sdram_fifo_arbiter_if
// Bundle between the arbiter and the SDRAM controller / FIFOs.
//   master (arbiter side):
//     out sdram_wr_req, sdram_wr_addr, sdram_wr_burst, wr_fifo_rden
//     out sdram_rd_req, sdram_rd_addr, sdram_rd_burst, rd_fifo_wren
//     in  sdram_wr_ack, wr_burst_finish, sdram_rd_ack, rd_burst_finish
//   slave (controller side): the same signals with directions reversed.
// -----------------------------------------------------------------------------
interface sdram_fifo_arbiter_if;
    import sdram_pkg::*;

    // write side
    logic                    sdram_wr_req;
    logic                    sdram_wr_ack;
    logic [ADDR_W-1:0]       sdram_wr_addr;
    logic [WR_BURST_W-1:0]   sdram_wr_burst;
    logic                    wr_burst_finish;
    logic                    wr_fifo_rden;

    // read side
    logic                    sdram_rd_req;
    logic                    sdram_rd_ack;
    logic [ADDR_W-1:0]       sdram_rd_addr;
    logic [RD_BURST_W-1:0]   sdram_rd_burst;
    logic                    rd_burst_finish;
    logic                    rd_fifo_wren;

    modport master (
        output sdram_wr_req, sdram_wr_addr, sdram_wr_burst, wr_fifo_rden,
        output sdram_rd_req, sdram_rd_addr, sdram_rd_burst, rd_fifo_wren,
        input  sdram_wr_ack, wr_burst_finish,
        input  sdram_rd_ack, rd_burst_finish
    );

    modport slave (
        input  sdram_wr_req, sdram_wr_addr, sdram_wr_burst, wr_fifo_rden,
        input  sdram_rd_req, sdram_rd_addr, sdram_rd_burst, rd_fifo_wren,
        output sdram_wr_ack, wr_burst_finish,
        output sdram_rd_ack, rd_burst_finish
    );

endinterface

// File: rtl/sdram_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_fifo_arbiter
// Watches the camera-side write FIFO and display-side read FIFO levels and
// issues one SDRAM burst request at a time, holding it until the controller
// acknowledges and the burst finishes. Keeps circular write/read frame-buffer
// pointers that advance by one burst per completed burst.
// Ports:
//   clk              in   SDRAM controller clock
//   rst_n            in   synchronous active-low reset
//   sdram_init_done  in   controller initialised; gates all requests
//   wr_fifo_level    in   words in the write FIFO
//   rd_fifo_level    in   words in the read FIFO
//   read_valid       in   display path enables reads
//   wr_min/max_addr  in   write region [min, max)
//   rd_min/max_addr  in   read region  [min, max)
//   wr_len, rd_len   in   burst lengths (nonzero)
//   wr_load, rd_load in   pointer restart pulses
//   bus              master modport towards controller and FIFOs
// -----------------------------------------------------------------------------
module sdram_fifo_arbiter
    import sdram_pkg::*;
#(
    parameter int LVL_W     = 10,
    parameter int RD_THRESH = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sdram_init_done,
    input  logic [LVL_W-1:0]      wr_fifo_level,
    input  logic [LVL_W-1:0]      rd_fifo_level,
    input  logic                  read_valid,
    input  logic [ADDR_W-1:0]     wr_min_addr,
    input  logic [ADDR_W-1:0]     wr_max_addr,
    input  logic [ADDR_W-1:0]     rd_min_addr,
    input  logic [ADDR_W-1:0]     rd_max_addr,
    input  logic [WR_BURST_W-1:0] wr_len,
    input  logic [RD_BURST_W-1:0] rd_len,
    input  logic                  wr_load,
    input  logic                  rd_load,
    sdram_fifo_arbiter_if.master  bus
);

    localparam logic [2:0] S_IDLE     = ST_IDLE;
    localparam logic [2:0] S_WR_REQ   = ST_WR_REQ;
    localparam logic [2:0] S_WR_BURST = ST_WR_BURST;
    localparam logic [2:0] S_RD_REQ   = ST_RD_REQ;
    localparam logic [2:0] S_RD_BURST = ST_RD_BURST;

    // One extra bit so a threshold equal to the FIFO depth is representable.
    localparam logic [LVL_W:0] RD_THRESH_W = (LVL_W + 1)'(RD_THRESH);

    logic [2:0]            r_state;
    logic                  r_last_wr;
    logic                  r_wr_req;
    logic                  r_rd_req;
    logic [WR_BURST_W-1:0] r_wr_burst;
    logic [RD_BURST_W-1:0] r_rd_burst;
    logic [ADDR_W-1:0]     r_wr_ptr;
    logic [ADDR_W-1:0]     r_rd_ptr;
    logic                  r_wr_load_pend;
    logic                  r_rd_load_pend;

    logic w_wr_pend;
    logic w_rd_pend;
    logic w_wr_busy;
    logic w_rd_busy;
    logic w_wr_done;
    logic w_rd_done;

    assign w_wr_pend = sdram_init_done && (wr_fifo_level >= LVL_W'(wr_len));
    assign w_rd_pend = sdram_init_done && read_valid &&
                       ({1'b0, rd_fifo_level} < RD_THRESH_W);

    assign w_wr_busy = (r_state == S_WR_REQ) || (r_state == S_WR_BURST);
    assign w_rd_busy = (r_state == S_RD_REQ) || (r_state == S_RD_BURST);

    // A finish pulse only counts for the side currently bursting.
    assign w_wr_done = (r_state == S_WR_BURST) && bus.wr_burst_finish;
    assign w_rd_done = (r_state == S_RD_BURST) && bus.rd_burst_finish;

    // -------------------------------------------------------------------------
    // Request state machine
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_last_wr  <= 1'b0;
            r_wr_req   <= 1'b0;
            r_rd_req   <= 1'b0;
            r_wr_burst <= '0;
            r_rd_burst <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // When both sides are pending, serve the one not served
                    // last; last_wr resets to 0 so a write wins first.
                    if (w_wr_pend && (!w_rd_pend || !r_last_wr)) begin
                        r_state    <= S_WR_REQ;
                        r_wr_req   <= 1'b1;
                        r_wr_burst <= wr_len;
                    end else if (w_rd_pend) begin
                        r_state    <= S_RD_REQ;
                        r_rd_req   <= 1'b1;
                        r_rd_burst <= rd_len;
                    end
                end
                S_WR_REQ: begin
                    if (bus.sdram_wr_ack) begin
                        r_wr_req <= 1'b0;
                        r_state  <= S_WR_BURST;
                    end
                end
                S_WR_BURST: begin
                    if (bus.wr_burst_finish) begin
                        r_last_wr <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                S_RD_REQ: begin
                    if (bus.sdram_rd_ack) begin
                        r_rd_req <= 1'b0;
                        r_state  <= S_RD_BURST;
                    end
                end
                S_RD_BURST: begin
                    if (bus.rd_burst_finish) begin
                        r_last_wr <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_wr_req <= 1'b0;
                    r_rd_req <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Write pointer. A restart request that arrives while a write is in
    // flight is deferred to the burst end so the address presented to the
    // controller never changes under an active burst. Uninitialised SDRAM
    // overrides everything and pins the pointer to the region start.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_wr_load_pend <= 1'b0;
        end else begin
            if (w_wr_done) begin
                r_wr_load_pend <= 1'b0;
                if (r_wr_load_pend || wr_load) begin
                    r_wr_ptr <= wr_min_addr;
                end else begin
                    r_wr_ptr <= next_ptr(r_wr_ptr, RD_BURST_W'(r_wr_burst),
                                         wr_min_addr, wr_max_addr);
                end
            end else if (wr_load) begin
                if (w_wr_busy) begin
                    r_wr_load_pend <= 1'b1;
                end else begin
                    r_wr_ptr <= wr_min_addr;
                end
            end
            if (!sdram_init_done) begin
                r_wr_ptr <= wr_min_addr;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read pointer, same rules as the write pointer.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_ptr       <= '0;
            r_rd_load_pend <= 1'b0;
        end else begin
            if (w_rd_done) begin
                r_rd_load_pend <= 1'b0;
                if (r_rd_load_pend || rd_load) begin
                    r_rd_ptr <= rd_min_addr;
                end else begin
                    r_rd_ptr <= next_ptr(r_rd_ptr, r_rd_burst,
                                         rd_min_addr, rd_max_addr);
                end
            end else if (rd_load) begin
                if (w_rd_busy) begin
                    r_rd_load_pend <= 1'b1;
                end else begin
                    r_rd_ptr <= rd_min_addr;
                end
            end
            if (!sdram_init_done) begin
                r_rd_ptr <= rd_min_addr;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.sdram_wr_req   = r_wr_req;
    assign bus.sdram_rd_req   = r_rd_req;
    assign bus.sdram_wr_addr  = r_wr_ptr;
    assign bus.sdram_rd_addr  = r_rd_ptr;
    assign bus.sdram_wr_burst = r_wr_burst;
    assign bus.sdram_rd_burst = r_rd_burst;

    // The controller's ack doubles as the FIFO strobe: the write FIFO is
    // show-ahead, so its head word is already valid when ack arrives.
    assign bus.wr_fifo_rden   = bus.sdram_wr_ack;
    assign bus.rd_fifo_wren   = bus.sdram_rd_ack;

endmodule

// File: doc/sdram_fifo_arbiter.md
# sdram_fifo_arbiter

Request arbiter and address generator sitting directly upstream of the SDRAM controller. It watches the fill levels of an external write FIFO (camera side) and read FIFO (display side), both in the 100 MHz SDRAM clock domain. It issues single burst write or read requests to the controller, holding each until the burst finishes, and advances circular frame-buffer address pointers.

## Interface
Parameters:
- `LVL_W`, 10: width of the FIFO level inputs.
- `RD_THRESH`, 512: a read is requested only while `rd_fifo_level < RD_THRESH`.

Ports:
- `clk`  in  1  SDRAM controller clock, 100 MHz; one clock, synchronous reset, active-low.
- `rst_n`  in  1  synchronous active-low reset.
- `sdram_init_done`  in  1  controller initialisation complete.
- `wr_fifo_level`  in  LVL_W  words held in the write FIFO.
- `rd_fifo_level`  in  LVL_W  words held in the read FIFO.
- `read_valid`  in  1  display path enables reads.
- `wr_min_addr`, `wr_max_addr`  in  21  write region bounds; min inclusive, max exclusive.
- `rd_min_addr`, `rd_max_addr`  in  21  read region bounds; min inclusive, max exclusive.
- `wr_len`  in  9  write burst length; nonzero.
- `rd_len`  in  10  read burst length; nonzero.
- `wr_load`, `rd_load`  in  1  pointer restart pulses.
- `sdram_wr_req`  out  1  write request to the controller.
- `sdram_wr_ack`  in  1  controller write acknowledge.
- `sdram_wr_addr`  out  21  write burst start address.
- `sdram_wr_burst`  out  9  write burst length.
- `wr_burst_finish`  in  1  write burst done pulse.
- `sdram_rd_req`  out  1  read request to the controller.
- `sdram_rd_ack`  in  1  controller read acknowledge.
- `sdram_rd_addr`  out  21  read burst start address.
- `sdram_rd_burst`  out  10  read burst length.
- `rd_burst_finish`  in  1  read burst done pulse.
- `wr_fifo_rden`  out  1  write FIFO read enable (show-ahead FIFO).
- `rd_fifo_wren`  out  1  read FIFO write enable.

## Operation
- State machine states: IDLE, WR_REQ, WR_BURST, RD_REQ, RD_BURST.
- Pending conditions:
  - `wr_pend = sdram_init_done && wr_fifo_level >= wr_len`
  - `rd_pend = sdram_init_done && read_valid && rd_fifo_level < RD_THRESH`
- IDLE selects the next burst:
  - Only `wr_pend` set: go to WR_REQ.
  - Only `rd_pend` set: go to RD_REQ.
  - Both set: serve the side opposite to the one served last (`last_wr` flag). After reset, write goes first.
- WR_REQ: hold `sdram_wr_req` high until `sdram_wr_ack` = 1, then move to WR_BURST with the request low.
- WR_BURST: wait for `wr_burst_finish`, then update the pointer, set `last_wr` = 1, and return to IDLE. RD_REQ/RD_BURST mirror this and set `last_wr` = 0.
- `sdram_wr_burst` = `wr_len` and `sdram_rd_burst` = `rd_len`. Both are latched on entry to the REQ state and held through BURST.
- `wr_fifo_rden = sdram_wr_ack` and `rd_fifo_wren = sdram_rd_ack`, both combinational.
- Pointer update at finish, computed in 22 bits: `nxt = ptr + len`. If `nxt + len > max_addr`, the pointer wraps to `min_addr`; otherwise it becomes `nxt`.
- While `sdram_init_done` = 0, both pointers continuously load their min addresses.
- Load pulses:
  - `wr_load` outside WR_REQ/WR_BURST sets `wr_ptr = wr_min_addr` on the next edge.
  - During a write request or burst, `wr_load` sets a pending flag instead. At finish the pointer loads `wr_min_addr` instead of incrementing, and the flag clears.
  - `rd_load` behaves the same way for the read side.
- `sdram_wr_addr`/`sdram_rd_addr` are the pointer registers.

## Timing
- Reset values: state IDLE, requests 0, addresses 0, burst outputs 0, `last_wr` 0, pending-load flags 0. Reset is sampled only on a `clk` edge.
- Request latency: a pending condition becoming true in IDLE raises the request on the next edge (1 cycle).
- Request deassertion: the request falls on the edge after the ack is sampled.
- Pointer: the updated pointer is visible 1 cycle after the finish pulse. The next request may rise in the cycle after IDLE is re-entered.
- Held inputs: level or threshold changes during WR_*/RD_* are ignored until IDLE.
- Unrelated inputs: a finish or ack for the side not in service is ignored.
- Reset mid-burst: everything returns to reset values, and the in-flight burst is abandoned.

## Structure
- Shared package `sdram_pkg` holds:
  - the state enum;
  - address width 21;
  - write burst width 9 and read burst width 10.
- No sub-modules. One pointer-update function (compute `nxt` and wrap) is reused for both sides.

## Test plan
- Basic write: `wr_min` 0, `wr_max` 1024, `wr_len` 256, level 300, ack 2 cycles after request.
  - Required: request 1 cycle after init; address 0, then 256, 512, 768, then wraps to 0.
- Alternation: both pending continuously, 4 bursts.
  - Required: order W, R, W, R; `rd_addr` sequence `rd_min`, `rd_min` + `rd_len`.
- Read threshold: `rd_fifo_level` 511 then 512, `read_valid` 1.
  - Required: request at 511; none at 512 in IDLE.
- Load during a burst: `wr_load` pulse during WR_BURST with `wr_ptr` 512.
  - Required: after finish, address = `wr_min`, not 768.
- Init gating: `sdram_init_done` 0 with the write FIFO full.
  - Required: no request and pointers track min addresses. After init rises, the first address = `wr_min_addr`.
- Mid-burst reset: `rst_n` low in RD_BURST.
  - Required: next edge shows requests 0, addresses 0, state IDLE; `rd_burst_finish` arriving afterwards is ignored.
